vector_add_arbiter: RTL and testbench
=====================================

// Module: vector_add_arbiter
// PURPOSE
//  Shares one vector_add unit between NUM_REQ requesters (e.g. delta update, weight update) in the
//  backprop datapath. Selects one requester round-robin, issues its a/b operands to vector_add,
//  captures the result and error flag, and returns them to the requester that issued them.
//  Only one transaction is in flight at a time. The vector_add instance sits directly behind this block.
// PARAMETERS
//  NUM_REQ           2  number of requesters (>=2)
//  VECTOR_LEN        5  cells per vector
//  A_CELL_WIDTH      8  bits per a cell
//  B_CELL_WIDTH      8  bits per b cell
//  RESULT_CELL_WIDTH 8  bits per result cell
// PORTS
//  clk              in   1                            clock, rising edge
//  rst              in   1                            synchronous reset, active-low (0 = reset)
//  req_a            in   NUM_REQ*VECTOR_LEN*A_CELL_WIDTH   requester a vectors, slot k at [k*VA+:VA]
//  req_b            in   NUM_REQ*VECTOR_LEN*B_CELL_WIDTH   requester b vectors, same packing
//  req_valid        in   NUM_REQ                      per-requester operand valid
//  req_ready        out  NUM_REQ                      per-requester accept, one-hot or zero
//  rsp_result       out  VECTOR_LEN*RESULT_CELL_WIDTH latched sum, shared by all requesters
//  rsp_error        out  1                            latched vector_add error for this result
//  rsp_valid        out  NUM_REQ                      result valid, one-hot to owner
//  rsp_ready        in   NUM_REQ                      per-requester result accept
//  add_a/add_b      out  VECTOR_LEN*A/B_CELL_WIDTH    operands to vector_add
//  add_a_valid/add_b_valid out 1 each; add_a_ready/add_b_ready in 1 each
//  add_result       in   VECTOR_LEN*RESULT_CELL_WIDTH; add_result_valid in 1; add_result_ready out 1
//  add_error        in   1                            vector_add error, sampled with add_result_valid
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE. All outputs 0. rsp_result=0. last_grant=NUM_REQ-1,
//   so requester 0 wins first. Reset mid-transaction drops it silently, and no rsp_valid is produced.
//   The vector_add instance must be reset on the same rst.
//  FSM IDLE -> ISSUE -> WAIT -> RETURN -> IDLE.
//  IDLE: winner g = first k with req_valid[k], searching last_grant+1 .. upward, with wrap-around.
//   req_ready[g]=1 combinationally in IDLE only. On req_valid[g]&&req_ready[g]: latch req_a/req_b slot g
//   into add_a/add_b, store grant=g, clear a_done/b_done, and go to ISSUE. No valid requester: stay in IDLE.
//  ISSUE: add_a_valid = !a_done and add_b_valid = !b_done. add_a_ready and add_b_ready are tracked
//   independently: a_done is set on add_a_valid&&add_a_ready, same for b. Both may complete in the same
//   cycle or in any order. When both are done (including same-cycle completion), go to WAIT.
//   add_a/add_b stay stable until then.
//  WAIT: add_result_ready=1. On add_result_valid: latch add_result->rsp_result and add_error->rsp_error,
//   then go to RETURN.
//  RETURN: rsp_valid[grant]=1, with rsp_result and rsp_error held stable. On rsp_ready[grant]:
//   last_grant=grant, then go to IDLE. A new grant happens no earlier than the next cycle.
//   rsp_ready of non-owners is ignored.
//  req_valid dropping after grant has no effect; operands are already latched.
//   req_valid asserted outside IDLE sees req_ready=0 and waits.
//  Fairness: a requester holding req_valid is granted within NUM_REQ transactions.
//  Latency: cycle after acceptance enters ISSUE. Minimum accept->rsp_valid = 2 cycles plus vector_add latency.
//  No arithmetic here; result widths and error semantics are vector_add's.
// TESTING
//  1. Single requester 0: a={-50,40,30,20,-10}, b={1,2,-3,4,5} -> rsp_valid[0] once,
//     rsp_result={-49,42,27,24,-5}, rsp_error=0.
//  2. Both req_valid held: 4 transactions granted 0,1,0,1. Each rsp_valid goes only to its owner,
//     with that owner's sums.
//  3. add_b_ready delayed 5 cycles after add_a_ready -> add_a_valid drops after its handshake, and
//     add_b_valid stays high until its own; result is still correct.
//  4. a={127,-128,..}, b={127,-128,..} -> rsp_error=1 and latched until rsp_ready.
//  5. rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_result stable, req_ready stays 0 throughout.
//  6. rst=0 during WAIT -> all outputs 0 next cycle, no rsp_valid. Next request goes to requester 0.

Source files
------------

// File: rtl/vector_add_arbiter.sv
// vector_add_arbiter: round-robin front end that shares one vector_add unit
// between NUM_REQ requesters, one transaction in flight at a time.
module vector_add_arbiter #(
   parameter int NUM_REQ           = 2,
   parameter int VECTOR_LEN        = 5,
   parameter int A_CELL_WIDTH      = 8,
   parameter int B_CELL_WIDTH      = 8,
   parameter int RESULT_CELL_WIDTH = 8
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [NUM_REQ*VECTOR_LEN*A_CELL_WIDTH-1:0]  req_a,
   input  logic [NUM_REQ*VECTOR_LEN*B_CELL_WIDTH-1:0]  req_b,
   input  logic [NUM_REQ-1:0]                          req_valid,
   output logic [NUM_REQ-1:0]                          req_ready,
   output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0]     rsp_result,
   output logic                                        rsp_error,
   output logic [NUM_REQ-1:0]                          rsp_valid,
   input  logic [NUM_REQ-1:0]                          rsp_ready,
   output logic [VECTOR_LEN*A_CELL_WIDTH-1:0]          add_a,
   output logic                                        add_a_valid,
   input  logic                                        add_a_ready,
   output logic [VECTOR_LEN*B_CELL_WIDTH-1:0]          add_b,
   output logic                                        add_b_valid,
   input  logic                                        add_b_ready,
   input  logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0]     add_result,
   input  logic                                        add_result_valid,
   output logic                                        add_result_ready,
   input  logic                                        add_error
);

   localparam int VA = VECTOR_LEN * A_CELL_WIDTH;
   localparam int VB = VECTOR_LEN * B_CELL_WIDTH;
   localparam int VR = VECTOR_LEN * RESULT_CELL_WIDTH;
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

   state_t          state_reg, state_next;
   logic [GW-1:0]   grant_reg;
   logic [GW-1:0]   last_grant_reg;
   logic            a_done_reg, b_done_reg;
   logic [VA-1:0]   add_a_reg;
   logic [VB-1:0]   add_b_reg;
   logic [VR-1:0]   rsp_result_reg;
   logic            rsp_error_reg;

   logic [GW-1:0]   win;
   logic            win_found;
   logic [GW:0]     cand;
   logic            accept;
   logic            rsp_ack;
   logic            a_hs, b_hs;

   logic [VA-1:0]   req_a_slot [NUM_REQ];
   logic [VB-1:0]   req_b_slot [NUM_REQ];

   // Per-requester operand unpacking and one-hot handshake outputs.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign req_a_slot[gi] = req_a[gi*VA +: VA];
         assign req_b_slot[gi] = req_b[gi*VB +: VB];
         // req_ready is combinational on req_valid, so it is held low while reset is asserted.
         assign req_ready[gi]  = rst && (state_reg == IDLE) && win_found && (win == GW'(gi));
         assign rsp_valid[gi]  = (state_reg == RETURN) && (grant_reg == GW'(gi));
      end
   endgenerate

   assign accept     = |(req_valid & req_ready);
   assign rsp_ack    = |(rsp_valid & rsp_ready);
   assign add_a      = add_a_reg;
   assign add_b      = add_b_reg;
   assign rsp_result = rsp_result_reg;
   assign rsp_error  = rsp_error_reg;

   // Round-robin search: first valid requester after last_grant, wrapping around.
   always_comb begin
      win       = '0;
      win_found = 1'b0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = {1'b0, last_grant_reg} + (GW+1)'(i);
         if (cand >= (GW+1)'(NUM_REQ)) begin
            cand = cand - (GW+1)'(NUM_REQ);
         end
         if (!win_found && req_valid[cand[GW-1:0]]) begin
            win_found = 1'b1;
            win       = cand[GW-1:0];
         end
      end
   end

   // FSM next-state and vector_add handshake outputs.
   always_comb begin
      state_next       = state_reg;
      add_a_valid      = 1'b0;
      add_b_valid      = 1'b0;
      add_result_ready = 1'b0;
      a_hs             = 1'b0;
      b_hs             = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) state_next = ISSUE;
         end
         ISSUE: begin
            // a and b handshake independently; leave once both have gone through.
            add_a_valid = !a_done_reg;
            add_b_valid = !b_done_reg;
            a_hs        = add_a_valid && add_a_ready;
            b_hs        = add_b_valid && add_b_ready;
            if ((a_done_reg || a_hs) && (b_done_reg || b_hs)) state_next = WAIT;
         end
         WAIT: begin
            add_result_ready = 1'b1;
            if (add_result_valid) state_next = RETURN;
         end
         RETURN: begin
            if (rsp_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   // Operand, grant and result registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         grant_reg      <= '0;
         last_grant_reg <= GW'(NUM_REQ - 1);
         a_done_reg     <= 1'b0;
         b_done_reg     <= 1'b0;
         add_a_reg      <= '0;
         add_b_reg      <= '0;
         rsp_result_reg <= '0;
         rsp_error_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  add_a_reg  <= req_a_slot[win];
                  add_b_reg  <= req_b_slot[win];
                  grant_reg  <= win;
                  a_done_reg <= 1'b0;
                  b_done_reg <= 1'b0;
               end
            end
            ISSUE: begin
               if (a_hs) a_done_reg <= 1'b1;
               if (b_hs) b_done_reg <= 1'b1;
            end
            WAIT: begin
               if (add_result_valid) begin
                  rsp_result_reg <= add_result;
                  rsp_error_reg  <= add_error;
               end
            end
            RETURN: begin
               if (rsp_ack) last_grant_reg <= grant_reg;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_add_arbiter.sv
// Testbench for vector_add_arbiter with a behavioural vector_add stand-in,
// table-driven transactions and a response scoreboard.
module tb_vector_add_arbiter;

   localparam int NR = 2;
   localparam int VA = 40;
   localparam int VR = 40;

   typedef struct {
      int            req;
      logic [VA-1:0] a;
      logic [VA-1:0] b;
      logic [VR-1:0] res;
      logic          err;
   } vec_t;

   typedef struct {
      int            req;
      logic [VR-1:0] res;
      logic          err;
   } sb_t;

   logic              clk;
   logic              rst;
   logic [NR*VA-1:0]  req_a;
   logic [NR*VA-1:0]  req_b;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [VR-1:0]     rsp_result;
   logic              rsp_error;
   logic [NR-1:0]     rsp_valid;
   logic [NR-1:0]     rsp_ready;
   logic [VA-1:0]     add_a;
   logic              add_a_valid;
   logic              add_a_ready;
   logic [VA-1:0]     add_b;
   logic              add_b_valid;
   logic              add_b_ready;
   logic [VR-1:0]     add_result;
   logic              add_result_valid;
   logic              add_result_ready;
   logic              add_error;

   vector_add_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .req_a            (req_a),
      .req_b            (req_b),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .rsp_result       (rsp_result),
      .rsp_error        (rsp_error),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .add_a            (add_a),
      .add_a_valid      (add_a_valid),
      .add_a_ready      (add_a_ready),
      .add_b            (add_b),
      .add_b_valid      (add_b_valid),
      .add_b_ready      (add_b_ready),
      .add_result       (add_result),
      .add_result_valid (add_result_valid),
      .add_result_ready (add_result_ready),
      .add_error        (add_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   vec_t tbl [8];
   sb_t  sb [$];
   int   q0 [$];
   int   q1 [$];
   int   grant_log [$];
   int   cur [NR];

   int   a_delay = 0;
   int   b_delay = 0;
   int   res_lat = 1;
   int   rsp_delay = 0;
   int   rv_cnt = 0;

   logic [VA-1:0] exp_a, exp_b;
   bit            a_tb = 0, b_tb = 0;
   bit            pend_rsp = 0;
   logic [NR-1:0] prev_rv;
   logic [VR-1:0] prev_res;
   logic          prev_err;
   bit            saw_wait = 0;
   int            txn_no = 0;

   // ---------------- vector_add stand-in: wrapping signed add, error on any cell overflow
   function automatic logic [VR-1:0] vsum(input logic [VA-1:0] a, input logic [VA-1:0] b);
      logic [VR-1:0] r;
      r = '0;
      for (int i = 0; i < 5; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
      return r;
   endfunction

   function automatic logic verr(input logic [VA-1:0] a, input logic [VA-1:0] b);
      logic       e;
      logic [7:0] s;
      e = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s = a[i*8 +: 8] + b[i*8 +: 8];
         if (a[i*8+7] == b[i*8+7] && s[7] != a[i*8+7]) e = 1'b1;
      end
      return e;
   endfunction

   int            m_a_cnt, m_b_cnt, m_res_cnt;
   bit            m_a_got, m_b_got;
   logic [VA-1:0] m_a_cap, m_b_cap;

   always @(posedge clk) begin
      if (!rst) begin
         add_a_ready      <= 1'b0;
         add_b_ready      <= 1'b0;
         add_result_valid <= 1'b0;
         add_result       <= '0;
         add_error        <= 1'b0;
         m_a_cnt <= 0; m_b_cnt <= 0; m_res_cnt <= 0;
         m_a_got <= 0; m_b_got <= 0;
      end else begin
         if (add_a_valid && add_a_ready) begin
            m_a_got <= 1; m_a_cap <= add_a; add_a_ready <= 1'b0;
         end else if (add_a_valid && !m_a_got) begin
            if (m_a_cnt >= a_delay) add_a_ready <= 1'b1;
            else                    m_a_cnt <= m_a_cnt + 1;
         end
         if (add_b_valid && add_b_ready) begin
            m_b_got <= 1; m_b_cap <= add_b; add_b_ready <= 1'b0;
         end else if (add_b_valid && !m_b_got) begin
            if (m_b_cnt >= b_delay) add_b_ready <= 1'b1;
            else                    m_b_cnt <= m_b_cnt + 1;
         end
         if (m_a_got && m_b_got && !add_result_valid) begin
            if (m_res_cnt >= res_lat) begin
               add_result_valid <= 1'b1;
               add_result       <= vsum(m_a_cap, m_b_cap);
               add_error        <= verr(m_a_cap, m_b_cap);
            end else begin
               m_res_cnt <= m_res_cnt + 1;
            end
         end
         if (add_result_valid && add_result_ready) begin
            add_result_valid <= 1'b0;
            m_a_got <= 0; m_b_got <= 0;
            m_a_cnt <= 0; m_b_cnt <= 0; m_res_cnt <= 0;
         end
      end
   end

   // ---------------- helpers
   function automatic logic [39:0] pack5(input int c0, input int c1, input int c2,
                                         input int c3, input int c4);
      logic [39:0] v;
      v[7:0]   = c0[7:0];
      v[15:8]  = c1[7:0];
      v[23:16] = c2[7:0];
      v[31:24] = c3[7:0];
      v[39:32] = c4[7:0];
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic sched(input int idx);
      if (tbl[idx].req == 0) q0.push_back(idx);
      else                   q1.push_back(idx);
   endtask

   task automatic load(input int k);
      int idx;
      bit have;
      have = 0;
      idx  = 0;
      if (k == 0 && q0.size() > 0) begin idx = q0.pop_front(); have = 1; end
      if (k == 1 && q1.size() > 0) begin idx = q1.pop_front(); have = 1; end
      if (have) begin
         cur[k] = idx;
         req_a[k*VA +: VA] = tbl[idx].a;
         req_b[k*VA +: VA] = tbl[idx].b;
         req_valid[k] = 1'b1;
      end else begin
         req_valid[k] = 1'b0;
      end
   endtask

   task automatic kick();
      for (int k = 0; k < NR; k++) if (!req_valid[k]) load(k);
   endtask

   // One clock: observe at the falling edge, update stimulus just after the rising edge.
   task automatic cycle();
      logic [NR-1:0] acc;
      logic [NR-1:0] own;
      sb_t           e;
      @(negedge clk);
      acc = req_valid & req_ready;
      chk("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      chk("rsp_valid_onehot0", 64'($onehot0(rsp_valid)), 64'd1);
      if (add_result_ready) saw_wait = 1;
      for (int k = 0; k < NR; k++) begin
         if (acc[k]) begin
            e.req = k;
            e.res = tbl[cur[k]].res;
            e.err = tbl[cur[k]].err;
            sb.push_back(e);
            grant_log.push_back(k);
            exp_a = tbl[cur[k]].a;
            exp_b = tbl[cur[k]].b;
         end
      end
      if (a_tb && !b_tb) begin
         chk("add_a_valid_dropped", 64'(add_a_valid), 64'd0);
         chk("add_b_valid_held", 64'(add_b_valid), 64'd1);
      end
      if (b_tb && !a_tb) begin
         chk("add_b_valid_dropped", 64'(add_b_valid), 64'd0);
         chk("add_a_valid_held", 64'(add_a_valid), 64'd1);
      end
      if (add_a_valid && add_a_ready) begin chk("add_a_operand", 64'(add_a), 64'(exp_a)); a_tb = 1; end
      if (add_b_valid && add_b_ready) begin chk("add_b_operand", 64'(add_b), 64'(exp_b)); b_tb = 1; end
      if (a_tb && b_tb) begin a_tb = 0; b_tb = 0; end
      if (rsp_valid != 0) chk("req_ready_low_in_return", 64'(req_ready), 64'd0);
      if (pend_rsp) begin
         chk("rsp_valid_stable", 64'(rsp_valid), 64'(prev_rv));
         chk("rsp_result_stable", 64'(rsp_result), 64'(prev_res));
         chk("rsp_error_stable", 64'(rsp_error), 64'(prev_err));
      end
      if ((rsp_valid & rsp_ready) != 0) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_unexpected: got rsp_valid=%b, expected no response", rsp_valid);
         end else begin
            e = sb.pop_front();
            own = '0;
            own[e.req] = 1'b1;
            chk("rsp_owner", 64'(rsp_valid), 64'(own));
            chk("rsp_result", 64'(rsp_result), 64'(e.res));
            chk("rsp_error", 64'(rsp_error), 64'(e.err));
            $display("txn %0d: req=%0d result=%h error=%b", txn_no, e.req, rsp_result, rsp_error);
            txn_no++;
         end
         pend_rsp = 0;
      end else begin
         pend_rsp = (rsp_valid != 0);
         prev_rv  = rsp_valid;
         prev_res = rsp_result;
         prev_err = rsp_error;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) if (acc[k]) load(k);
      if (rsp_valid != 0) begin
         rv_cnt++;
         // Until the owner accepts, only non-owners assert rsp_ready; those must be ignored.
         rsp_ready = (rv_cnt > rsp_delay) ? rsp_valid : ~rsp_valid;
      end else begin
         rv_cnt    = 0;
         rsp_ready = '0;
      end
   endtask

   task automatic run(input int budget);
      int n;
      n = 0;
      kick();
      while ((req_valid != 0 || sb.size() != 0) && n < budget) begin
         cycle();
         n++;
      end
      chk("run_within_budget", 64'(n < budget), 64'd1);
   endtask

   // ---------------- main sequence
   initial begin
      tbl[0] = '{0, pack5(-50, 40, 30, 20, -10), pack5(1, 2, -3, 4, 5),
                 pack5(-49, 42, 27, 24, -5), 1'b0};
      tbl[1] = '{1, pack5(1, 2, 3, 4, 5), pack5(10, 20, 30, 40, 50),
                 pack5(11, 22, 33, 44, 55), 1'b0};
      tbl[2] = '{0, pack5(-1, -2, -3, -4, -5), pack5(-10, -20, -30, -40, -50),
                 pack5(-11, -22, -33, -44, -55), 1'b0};
      tbl[3] = '{1, pack5(100, 0, 0, 0, 0), pack5(27, 0, 0, 0, 0),
                 pack5(127, 0, 0, 0, 0), 1'b0};
      tbl[4] = '{0, pack5(-100, 5, 5, 5, 5), pack5(-28, -5, -5, -5, -5),
                 pack5(-128, 0, 0, 0, 0), 1'b0};
      tbl[5] = '{1, pack5(127, -128, 100, -100, 1), pack5(127, -128, 100, -100, 2),
                 pack5(-2, 0, -56, 56, 3), 1'b1};
      tbl[6] = '{0, pack5(64, 0, 0, 0, 0), pack5(64, 0, 0, 0, 0),
                 pack5(-128, 0, 0, 0, 0), 1'b1};
      tbl[7] = '{1, pack5(0, 0, 0, 0, 0), pack5(-1, -1, -1, -1, -1),
                 pack5(-1, -1, -1, -1, -1), 1'b0};

      // Reset with requests pending: every output must still read zero.
      rst = 1'b0; req_a = '0; req_b = '0; req_valid = 2'b11; rsp_ready = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_result", 64'(rsp_result), 64'd0);
      chk("reset_rsp_error", 64'(rsp_error), 64'd0);
      chk("reset_add_valids", 64'({add_a_valid, add_b_valid, add_result_ready}), 64'd0);
      chk("reset_add_ops", 64'(add_a | add_b), 64'd0);
      @(posedge clk); #1;
      req_valid = '0;
      rst = 1'b1;

      // Single requester 0.
      sched(0); run(200);
      // Single requester 1, leaving last_grant at 1.
      sched(1); run(200);

      // Both requesters held: grants alternate 0,1,0,1.
      grant_log.delete();
      sched(2); sched(4); sched(3); sched(7);
      run(400);
      chk("rr_count", 64'(grant_log.size()), 64'd4);
      for (int i = 0; i < grant_log.size() && i < 4; i++)
         chk("rr_order", 64'(grant_log[i]), 64'(i % 2));

      // add_b_ready 5 cycles behind add_a_ready.
      b_delay = 5;
      sched(6); run(200);
      b_delay = 0;

      // Overflow result with error flag held while the owner stalls.
      rsp_delay = 3;
      sched(5); run(200);

      // Long response stall with the other requester waiting.
      rsp_delay = 10;
      sched(0); sched(1); run(400);
      rsp_delay = 0;

      // Reset during WAIT: leave last_grant at 0, then drop a requester-1 transaction.
      sched(4); run(200);
      res_lat = 20;
      saw_wait = 0;
      sched(7); kick();
      for (int n = 0; n < 100 && !saw_wait; n++) cycle();
      chk("reached_wait", 64'(saw_wait), 64'd1);
      rst = 1'b0; req_valid = '0; rsp_ready = '0;
      @(posedge clk);
      @(negedge clk);
      chk("midreset_req_ready", 64'(req_ready), 64'd0);
      chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midreset_rsp_result", 64'(rsp_result), 64'd0);
      chk("midreset_rsp_error", 64'(rsp_error), 64'd0);
      chk("midreset_add_valids", 64'({add_a_valid, add_b_valid, add_result_ready}), 64'd0);
      chk("midreset_add_ops", 64'(add_a | add_b), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      sb.delete();
      a_tb = 0; b_tb = 0; pend_rsp = 0; rv_cnt = 0;
      res_lat = 1;
      grant_log.delete();
      sched(0); sched(1);
      run(400);
      chk("post_reset_count", 64'(grant_log.size()), 64'd2);
      if (grant_log.size() > 0) chk("post_reset_first_grant", 64'(grant_log[0]), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
